// File: rtl/sam_audio_mixer_n.sv
// sam_audio_mixer_n: NCH-channel PCM mixer with per-channel volume and pan.
// One multiply-accumulate per clock walks the channels after each sample strobe.
// The latched left/right mixes feed two first-order sigma-delta 1-bit DACs.
module sam_audio_mixer_n #(
  parameter  int NCH = 4,
  parameter  int IW  = 8,
  parameter  int VW  = 4,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int SW  = IW + VW + CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [NCH*IW-1:0] ch_data,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_ch,
  input  logic [VW-1:0]     wr_vol,
  input  logic [1:0]        wr_pan,
  input  logic              mute,
  output logic [IW-1:0]     pcm_left,
  output logic [IW-1:0]     pcm_right,
  output logic              pcm_valid,
  output logic              overrun,
  output logic              audio_left,
  output logic              audio_right
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CW-1:0] LAST  = CW'(NCH - 1);
  localparam logic [CW:0]   NCH_C = (CW + 1)'(NCH);

  state_t              state_reg, state_next;
  logic [CW-1:0]       idx_reg;
  logic [NCH*IW-1:0]   snap_reg;
  logic [SW-1:0]       acc_l_reg, acc_r_reg;
  logic [IW-1:0]       pcm_left_reg, pcm_right_reg;
  logic                pcm_valid_reg, overrun_reg;
  logic [VW-1:0]       vol_reg [NCH];
  logic [1:0]          pan_reg [NCH];

  // Current channel's operands; vol/pan are read live so a same-edge write lands after this use.
  logic [IW-1:0]       cur_sample;
  logic [VW-1:0]       cur_vol;
  logic [1:0]          cur_pan;
  logic [IW+VW-1:0]    prod;
  logic                wr_ok;

  assign cur_sample = snap_reg[idx_reg*IW +: IW];
  assign cur_vol    = vol_reg[idx_reg];
  assign cur_pan    = pan_reg[idx_reg];
  assign prod       = (IW + VW)'(cur_sample) * (IW + VW)'(cur_vol);
  assign wr_ok      = wr_en && ({1'b0, wr_ch} < NCH_C);

  // Per-channel volume/pan registers; out-of-range channel writes match no channel.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chreg
    always_ff @(posedge clk) begin
      if (rst) begin
        vol_reg[gi] <= '1;
        pan_reg[gi] <= 2'b11;
      end else if (wr_ok && (wr_ch == CW'(gi))) begin
        vol_reg[gi] <= wr_vol;
        pan_reg[gi] <= wr_pan;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: strobe starts a scan, last channel moves to latch, latch returns to idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ce) state_next = SCAN;
      SCAN:    if (idx_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: snapshot, multiply-accumulate per channel, latch the top IW bits of each sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      snap_reg      <= '0;
      acc_l_reg     <= '0;
      acc_r_reg     <= '0;
      pcm_left_reg  <= '0;
      pcm_right_reg <= '0;
      pcm_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      pcm_valid_reg <= 1'b0;
      overrun_reg   <= ce && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (ce) begin
            snap_reg  <= ch_data;
            acc_l_reg <= '0;
            acc_r_reg <= '0;
            idx_reg   <= '0;
          end
        end
        SCAN: begin
          acc_l_reg <= acc_l_reg + (cur_pan[1] ? SW'(prod) : '0);
          acc_r_reg <= acc_r_reg + (cur_pan[0] ? SW'(prod) : '0);
          if (idx_reg != LAST) idx_reg <= idx_reg + CW'(1);
        end
        DONE: begin
          pcm_left_reg  <= mute ? '0 : acc_l_reg[SW-1 -: IW];
          pcm_right_reg <= mute ? '0 : acc_r_reg[SW-1 -: IW];
          pcm_valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pcm_left  = pcm_left_reg;
  assign pcm_right = pcm_right_reg;
  assign pcm_valid = pcm_valid_reg;
  assign overrun   = overrun_reg;

  // Sigma-delta DACs: index 0 is left, 1 is right; carry out of the accumulator is the bit.
  logic [IW-1:0] dac_pcm [2];
  logic [1:0]    audio_reg;

  assign dac_pcm[0] = pcm_left_reg;
  assign dac_pcm[1] = pcm_right_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dac
    logic [IW-1:0] dacacc_reg;
    logic [IW:0]   dac_sum;

    assign dac_sum = {1'b0, dacacc_reg} + {1'b0, dac_pcm[gi]};

    // Accumulate every clock, independent of the sample strobe.
    always_ff @(posedge clk) begin
      if (rst) begin
        dacacc_reg    <= '0;
        audio_reg[gi] <= 1'b0;
      end else begin
        dacacc_reg    <= dac_sum[IW-1:0];
        audio_reg[gi] <= dac_sum[IW];
      end
    end
  end

  assign audio_left  = audio_reg[0];
  assign audio_right = audio_reg[1];

endmodule

// File: tb/tb_sam_audio_mixer_n.sv
// tb_sam_audio_mixer_n: directed and randomized checks of the mixer against
// an arithmetic reference (weighted channel sums and ones-density of the DAC).
module tb_sam_audio_mixer_n;

  localparam int NCH   = 4;
  localparam int IW    = 8;
  localparam int VW    = 4;
  localparam int CW    = 2;
  localparam int SHIFT = VW + CW;  // sum width minus output width

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ce = 1'b0;
  logic [NCH*IW-1:0] ch_data = '0;
  logic              wr_en = 1'b0;
  logic [CW-1:0]     wr_ch = '0;
  logic [VW-1:0]     wr_vol = '0;
  logic [1:0]        wr_pan = '0;
  logic              mute = 1'b0;
  logic [IW-1:0]     pcm_left, pcm_right;
  logic              pcm_valid, overrun, audio_left, audio_right;

  sam_audio_mixer_n #(.NCH(NCH), .IW(IW), .VW(VW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .ch_data(ch_data),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_vol(wr_vol), .wr_pan(wr_pan),
    .mute(mute), .pcm_left(pcm_left), .pcm_right(pcm_right),
    .pcm_valid(pcm_valid), .overrun(overrun),
    .audio_left(audio_left), .audio_right(audio_right)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference register file.
  int         m_vol [NCH];
  logic [1:0] m_pan [NCH];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_vol[i] = 15;
      m_pan[i] = 2'b11;
    end
  endtask

  // side: 1 = left (pan bit1), 0 = right (pan bit0)
  function automatic int model_mix(input logic [NCH*IW-1:0] d, input int side, input bit m);
    int s = 0;
    for (int i = 0; i < NCH; i++)
      if (m_pan[i][side]) s += int'(d[i*IW +: IW]) * m_vol[i];
    return m ? 0 : (s >> SHIFT);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic write_reg(input int ch, input int vol, input logic [1:0] pan);
    wr_en  = 1'b1;
    wr_ch  = CW'(ch);
    wr_vol = VW'(vol);
    wr_pan = pan;
    tick();
    wr_en = 1'b0;
    if (ch < NCH) begin
      m_vol[ch] = vol;
      m_pan[ch] = pan;
    end
    $display("[TB] write ch=%0d vol=%0d pan=%b", ch, vol, pan);
  endtask

  // One strobe, then watch enough edges for latency, pulse count and results.
  task automatic do_mix(input logic [NCH*IW-1:0] d, input bit m, input string tag);
    int nvalid = 0, lat = -1, pl = -1, pr = -1;
    int el, er;
    el = model_mix(d, 1, m);
    er = model_mix(d, 0, m);
    ch_data = d;
    mute    = m;
    ce      = 1'b1;
    tick();
    ce = 1'b0;
    for (int k = 1; k <= NCH + 4; k++) begin
      tick();
      if (pcm_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = k;
          pl  = int'(pcm_left);
          pr  = int'(pcm_right);
        end
      end
    end
    mute = 1'b0;
    check({tag, " latency"}, lat, NCH + 1);
    check({tag, " valid_count"}, nvalid, 1);
    check({tag, " left"}, pl, el);
    check({tag, " right"}, pr, er);
    $display("[TB] mix %s data=%h mute=%0d left=%0d right=%0d exp=%0d/%0d", tag, d, m, pl, pr, el, er);
  endtask

  // Count ones on the DAC output over 256 clocks; also count equal neighbours.
  task automatic density(input bit left, output int ones, output int same);
    logic prev, cur;
    ones = 0;
    same = 0;
    prev = left ? audio_left : audio_right;
    for (int k = 0; k < 256; k++) begin
      tick();
      cur = left ? audio_left : audio_right;
      if (cur) ones++;
      if (cur == prev) same++;
      prev = cur;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got hang, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ones, same, nvalid, nover, lat, pl, pr, a_ones;
    logic [NCH*IW-1:0] d_a, d_b;

    do_reset();
    check("reset pcm_left", int'(pcm_left), 0);
    check("reset pcm_right", int'(pcm_right), 0);
    check("reset pcm_valid", int'(pcm_valid), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset audio_left", int'(audio_left), 0);
    check("reset audio_right", int'(audio_right), 0);

    // All channels full scale at full volume.
    do_mix({NCH{8'hFF}}, 1'b0, "allff");
    check("allff left const", int'(pcm_left), 239);

    // Single channel at half scale, then DAC ones density.
    do_mix(32'h0000_0080, 1'b0, "half");
    density(1'b1, ones, same);
    check("half density_left", ones, 30);

    // Right-only pan on ch0.
    write_reg(0, 15, 2'b01);
    do_mix(32'h0000_00FF, 1'b0, "pan");
    check("pan right const", int'(pcm_right), 59);

    // Volumes of ch1..3 zero, pan restored, then muted.
    write_reg(0, 15, 2'b11);
    for (int i = 1; i < NCH; i++) write_reg(i, 0, 2'b11);
    do_mix({NCH{8'hFF}}, 1'b0, "vol0");
    check("vol0 left const", int'(pcm_left), 59);
    do_mix({NCH{8'hFF}}, 1'b1, "mute");

    // Second strobe three cycles into a scan.
    do_reset();
    d_a = 32'h1020_3040;
    d_b = 32'hFFFF_FFFF;
    nvalid = 0; nover = 0; lat = -1; pl = -1; pr = -1;
    ch_data = d_a;
    ce = 1'b1;
    tick();
    ce = 1'b0;
    for (int k = 1; k <= NCH + 5; k++) begin
      if (k == 3) begin
        ch_data = d_b;
        ce = 1'b1;
      end
      tick();
      ce = 1'b0;
      if (overrun) nover++;
      if (pcm_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = k; pl = int'(pcm_left); pr = int'(pcm_right);
        end
      end
    end
    check("ovr overrun_count", nover, 1);
    check("ovr valid_count", nvalid, 1);
    check("ovr latency", lat, NCH + 1);
    check("ovr left", pl, model_mix(d_a, 1, 1'b0));
    check("ovr right", pr, model_mix(d_a, 0, 1'b0));
    $display("[TB] overrun test overruns=%0d valids=%0d left=%0d right=%0d", nover, nvalid, pl, pr);

    // pcm = 128 gives an alternating bitstream.
    do_mix({8'h00, 8'h25, 8'hFF, 8'hFF}, 1'b0, "pcm128");
    check("pcm128 const", int'(pcm_left), 128);
    density(1'b1, ones, same);
    check("pcm128 density_left", ones, 128);
    check("pcm128 no_repeat", same, 0);
    density(1'b0, ones, same);
    check("pcm128 density_right", ones, 128);

    // Reset in the middle of a scan.
    ch_data = {NCH{8'hFF}};
    ce = 1'b1;
    tick();
    ce = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    nvalid = 0; a_ones = 0;
    for (int k = 0; k < NCH + 6; k++) begin
      tick();
      if (pcm_valid) nvalid++;
      if (audio_left || audio_right) a_ones++;
    end
    check("rstscan valid_count", nvalid, 0);
    check("rstscan pcm_left", int'(pcm_left), 0);
    check("rstscan pcm_right", int'(pcm_right), 0);
    check("rstscan audio_ones", a_ones, 0);
    $display("[TB] reset mid-scan valids=%0d audio_ones=%0d", nvalid, a_ones);
    do_mix({NCH{8'hFF}}, 1'b0, "post_rst");

    // Randomized register writes, samples and mute.
    for (int it = 0; it < 24; it++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++)
        write_reg(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)));
      do_mix($urandom, ($urandom_range(0, 3) == 0), $sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
